// File: rtl/pixel_uart_streamer.sv
// Pixel-to-UART streamer: reads RGB pixels from a synchronous-read RAM and
// writes them byte-by-byte into the UART TX FIFO as grayscale, replicated
// grayscale or raw RGB. Flow control is taken from tx_full.
module pixel_uart_streamer #(
    parameter int ADDR_BITS   = 10,
    parameter int PIXEL_COUNT = 1024,
    parameter int GRAY_WR     = 77,
    parameter int GRAY_WG     = 150,
    parameter int GRAY_WB     = 29
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [1:0]           mode,
    input  logic [ADDR_BITS-1:0] base_addr,
    input  logic [ADDR_BITS-1:0] len,
    output logic [ADDR_BITS-1:0] mem_addr,
    input  logic [23:0]          mem_data,
    input  logic                 tx_full,
    output logic                 wr_uart,
    output logic [7:0]           w_data,
    output logic                 busy,
    output logic                 done
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_FETCH   = 3'd1,
        S_CAPTURE = 3'd2,
        S_SEND    = 3'd3,
        S_NEXT    = 3'd4,
        S_DONE    = 3'd5
    } state_t;

    localparam logic [1:0]         MODE_GRAY   = 2'd0;
    localparam logic [1:0]         MODE_RGB    = 2'd1;
    localparam logic [1:0]         MODE_GRAY3  = 2'd2;
    localparam logic [1:0]         MODE_RSVD   = 2'd3;
    localparam logic [ADDR_BITS:0] PIX_DEFAULT = (ADDR_BITS+1)'(PIXEL_COUNT);
    localparam logic [ADDR_BITS:0] PIX_ONE     = (ADDR_BITS+1)'(1);
    localparam logic [15:0]        W_R         = 16'(GRAY_WR);
    localparam logic [15:0]        W_G         = 16'(GRAY_WG);
    localparam logic [15:0]        W_B         = 16'(GRAY_WB);

    // Luma with weights summing to 256: the max sum is 255*256, so 16 bits
    // hold it and the upper byte is the 0..255 gray value.
    function automatic logic [7:0] luma8(input logic [23:0] rgb);
        logic [15:0] acc;
        acc = 16'(rgb[23:16]) * W_R + 16'(rgb[15:8]) * W_G + 16'(rgb[7:0]) * W_B;
        return 8'(acc >> 8);
    endfunction

    state_t                 state_q, state_d;
    logic [1:0]             mode_q, mode_d;
    logic [ADDR_BITS-1:0]   mem_addr_q, mem_addr_d;
    logic [ADDR_BITS:0]     pix_left_q, pix_left_d;
    logic [23:0]            pix_q, pix_d;
    logic [7:0]             gray_q, gray_d;
    logic [1:0]             byte_idx_q, byte_idx_d;
    logic                   wr_uart_q, wr_uart_d;
    logic [7:0]             w_data_q, w_data_d;
    logic                   busy_q, busy_d;
    logic                   done_q, done_d;

    logic                   last_byte_s;
    logic [7:0]             send_byte_s;

    // Byte selection for the current SEND slot and end-of-pixel detection.
    always_comb begin
        last_byte_s = 1'b1;
        send_byte_s = gray_q;
        if (mode_q == MODE_RGB || mode_q == MODE_GRAY3) begin
            last_byte_s = (byte_idx_q == 2'd2);
        end else begin
            last_byte_s = 1'b1;
        end
        if (mode_q == MODE_RGB) begin
            case (byte_idx_q)
                2'd0:    send_byte_s = pix_q[23:16];
                2'd1:    send_byte_s = pix_q[15:8];
                default: send_byte_s = pix_q[7:0];
            endcase
        end else begin
            send_byte_s = gray_q;
        end
    end

    // State register plus datapath/output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            mode_q     <= 2'd0;
            mem_addr_q <= '0;
            pix_left_q <= '0;
            pix_q      <= 24'd0;
            gray_q     <= 8'd0;
            byte_idx_q <= 2'd0;
            wr_uart_q  <= 1'b0;
            w_data_q   <= 8'd0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            mode_q     <= mode_d;
            mem_addr_q <= mem_addr_d;
            pix_left_q <= pix_left_d;
            pix_q      <= pix_d;
            gray_q     <= gray_d;
            byte_idx_q <= byte_idx_d;
            wr_uart_q  <= wr_uart_d;
            w_data_q   <= w_data_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    // Next-state logic; a start outside IDLE is simply not looked at.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_FETCH;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_FETCH:   state_d = S_CAPTURE;
            S_CAPTURE: state_d = S_SEND;
            S_SEND: begin
                if (!tx_full && last_byte_s) begin
                    state_d = S_NEXT;
                end else begin
                    state_d = S_SEND;
                end
            end
            S_NEXT: begin
                if (pix_left_q == PIX_ONE) begin
                    state_d = S_DONE;
                end else begin
                    state_d = S_FETCH;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Datapath and registered-output next values; mem_addr only moves in NEXT
    // so it stays put while a pixel is being sent.
    always_comb begin
        mode_d     = mode_q;
        mem_addr_d = mem_addr_q;
        pix_left_d = pix_left_q;
        pix_d      = pix_q;
        gray_d     = gray_q;
        byte_idx_d = byte_idx_q;
        wr_uart_d  = 1'b0;
        w_data_d   = w_data_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    mode_d     = (mode == MODE_RSVD) ? MODE_GRAY : mode;
                    mem_addr_d = base_addr;
                    pix_left_d = (len == '0) ? PIX_DEFAULT : {1'b0, len};
                end else begin
                    mode_d = mode_q;
                end
            end
            S_CAPTURE: begin
                pix_d      = mem_data;
                gray_d     = luma8(mem_data);
                byte_idx_d = 2'd0;
            end
            S_SEND: begin
                if (!tx_full) begin
                    wr_uart_d = 1'b1;
                    w_data_d  = send_byte_s;
                    if (last_byte_s) begin
                        byte_idx_d = byte_idx_q;
                    end else begin
                        byte_idx_d = byte_idx_q + 2'd1;
                    end
                end else begin
                    wr_uart_d = 1'b0;
                end
            end
            S_NEXT: begin
                pix_left_d = pix_left_q - PIX_ONE;
                if (pix_left_q != PIX_ONE) begin
                    mem_addr_d = mem_addr_q + ADDR_BITS'(1);
                end else begin
                    mem_addr_d = mem_addr_q;
                end
            end
            default: begin
                wr_uart_d = 1'b0;
            end
        endcase
        busy_d = (state_d == S_FETCH) || (state_d == S_CAPTURE) ||
                 (state_d == S_SEND)  || (state_d == S_NEXT);
        done_d = (state_d == S_DONE);
    end

    assign mem_addr = mem_addr_q;
    assign wr_uart  = wr_uart_q;
    assign w_data   = w_data_q;
    assign busy     = busy_q;
    assign done     = done_q;

endmodule

// File: tb/tb_pixel_uart_streamer.sv
// Self-checking bench for pixel_uart_streamer: a sync-read RAM model, a
// byte/address/cycle monitor and a reference model built from the stream
// format rules (per pixel: gray once, gray thrice, or R,G,B).
module tb_pixel_uart_streamer;

    localparam int NPIX = 1024;

    logic        clk = 1'b0;
    logic        reset, start, tx_full, wr_uart, busy, done;
    logic [1:0]  mode;
    logic [9:0]  base_addr, len, mem_addr;
    logic [23:0] mem_data;
    logic [7:0]  w_data;

    logic [23:0] ram [0:NPIX-1];

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    logic [7:0] got_b[$];
    int         got_a[$];
    int         got_c[$];
    logic [7:0] exp_b[$];
    int         exp_a[$];
    int         done_cnt, done_cyc, viol;
    logic       full_sampled = 1'b0;
    int         start_cyc, run_ok;
    logic       busy_early;

    pixel_uart_streamer dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .mode      (mode),
        .base_addr (base_addr),
        .len       (len),
        .mem_addr  (mem_addr),
        .mem_data  (mem_data),
        .tx_full   (tx_full),
        .wr_uart   (wr_uart),
        .w_data    (w_data),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc          <= cyc + 1;
        mem_data     <= ram[mem_addr];
        full_sampled <= tx_full;
    end

    always @(negedge clk) begin
        if (wr_uart === 1'b1) begin
            got_b.push_back(w_data);
            got_a.push_back(int'(mem_addr));
            got_c.push_back(cyc);
            if (full_sampled) viol++;
        end
        if (done === 1'b1) begin
            done_cnt++;
            done_cyc = cyc;
        end
    end

    task automatic build_expected(input int m, input int base, input int n);
        exp_b.delete();
        exp_a.delete();
        for (int p = 0; p < n; p++) begin
            int a, r, g, b, gy;
            a  = (base + p) % NPIX;
            r  = int'(ram[a][23:16]);
            g  = int'(ram[a][15:8]);
            b  = int'(ram[a][7:0]);
            gy = (77 * r + 150 * g + 29 * b) / 256;
            if (m == 1) begin
                exp_b.push_back(8'(r)); exp_b.push_back(8'(g)); exp_b.push_back(8'(b));
                repeat (3) exp_a.push_back(a);
            end else if (m == 2) begin
                repeat (3) begin exp_b.push_back(8'(gy)); exp_a.push_back(a); end
            end else begin
                exp_b.push_back(8'(gy)); exp_a.push_back(a);
            end
        end
    endtask

    task automatic do_run(input int m, input int base, input int l, input int stall_pct,
                          input bit noise, input bit start_at_done);
        got_b.delete(); got_a.delete(); got_c.delete();
        done_cnt = 0; viol = 0;
        @(negedge clk); #1;
        mode = 2'(m); base_addr = 10'(base); len = 10'(l); start = 1'b1;
        start_cyc = cyc;
        @(negedge clk); #1;
        start = 1'b0;
        busy_early = busy;
        for (int i = 0; i < 20000 && done_cnt == 0; i++) begin
            tx_full = (stall_pct > 0) ? ($urandom_range(99) < stall_pct) : 1'b0;
            if (noise && (i % 97 == 50)) begin
                start = 1'b1; mode = 2'($urandom_range(3));
                base_addr = 10'($urandom_range(1023)); len = 10'($urandom_range(1023));
            end else begin
                start = 1'b0;
            end
            @(negedge clk); #1;
        end
        start = 1'b0; tx_full = 1'b0;
        run_ok = (done_cnt != 0) ? 1 : 0;
        if (start_at_done && run_ok != 0) begin
            start = 1'b1; mode = 2'd1; base_addr = 10'd0; len = 10'd1;
            @(negedge clk); #1;
            start = 1'b0;
        end
        repeat (4) @(negedge clk);
        #1;
    endtask

    task automatic test_reset;
        reset = 1'b1; start = 1'b0; tx_full = 1'b0; mode = 2'd0;
        base_addr = 10'd0; len = 10'd0;
        repeat (3) @(negedge clk);
        #1;
        n_checks++; if (mem_addr !== 10'd0) begin n_fail++; $display("FAIL reset_mem_addr got=%h exp=000", mem_addr); end
        n_checks++; if (wr_uart !== 1'b0) begin n_fail++; $display("FAIL reset_wr_uart got=%b exp=0", wr_uart); end
        n_checks++; if (w_data !== 8'd0) begin n_fail++; $display("FAIL reset_w_data got=%h exp=00", w_data); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got=%b exp=0", busy); end
        n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done got=%b exp=0", done); end
        reset = 1'b0;
        @(negedge clk); #1;
    endtask

    task automatic test_gray_basic;
        logic [7:0] lit [3];
        lit[0] = 8'h4C; lit[1] = 8'h95; lit[2] = 8'h1C;
        ram[0] = 24'hFF0000; ram[1] = 24'h00FF00; ram[2] = 24'h0000FF;
        build_expected(0, 0, 3);
        do_run(0, 0, 3, 0, 1'b0, 1'b0);
        n_checks++; if (run_ok != 1) begin n_fail++; $display("FAIL gray_done_seen got=%0d exp=1", run_ok); end
        n_checks++; if (got_b.size() != 3) begin n_fail++; $display("FAIL gray_count got=%0d exp=3", got_b.size()); end
        for (int i = 0; i < 3 && i < got_b.size(); i++) begin
            n_checks++; if (got_b[i] !== lit[i]) begin n_fail++; $display("FAIL gray_byte%0d got=%h exp=%h", i, got_b[i], lit[i]); end
            n_checks++; if (got_c[i] - start_cyc != 4 + 4 * i) begin n_fail++; $display("FAIL gray_time%0d got=%0d exp=%0d", i, got_c[i] - start_cyc, 4 + 4 * i); end
        end
        n_checks++; if (done_cnt != 1) begin n_fail++; $display("FAIL gray_done_count got=%0d exp=1", done_cnt); end
        n_checks++; if (done_cyc - start_cyc != 13) begin n_fail++; $display("FAIL gray_done_time got=%0d exp=13", done_cyc - start_cyc); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL gray_busy_after got=%b exp=0", busy); end
    endtask

    task automatic test_rgb;
        ram[5] = 24'h123456; ram[6] = 24'hABCDEF;
        build_expected(1, 5, 2);
        do_run(1, 5, 2, 0, 1'b0, 1'b0);
        n_checks++; if (got_b.size() != 6) begin n_fail++; $display("FAIL rgb_count got=%0d exp=6", got_b.size()); end
        for (int i = 0; i < 6 && i < got_b.size(); i++) begin
            n_checks++; if (got_b[i] !== exp_b[i] || got_a[i] != exp_a[i]) begin
                n_fail++; $display("FAIL rgb_byte%0d got=%h@%h exp=%h@%h", i, got_b[i], got_a[i], exp_b[i], exp_a[i]); end
            n_checks++; if (got_c[i] - start_cyc != 4 + (i / 3) * 6 + (i % 3)) begin
                n_fail++; $display("FAIL rgb_time%0d got=%0d exp=%0d", i, got_c[i] - start_cyc, 4 + (i / 3) * 6 + (i % 3)); end
        end
        n_checks++; if (done_cnt != 1 || done_cyc - start_cyc != 13) begin
            n_fail++; $display("FAIL rgb_done got=%0d@%0d exp=1@13", done_cnt, done_cyc - start_cyc); end
    endtask

    task automatic test_gray3_latency;
        ram[0] = 24'hFFFFFF;
        do_run(2, 0, 1, 0, 1'b0, 1'b0);
        n_checks++; if (busy_early !== 1'b1) begin n_fail++; $display("FAIL g3_busy_early got=%b exp=1", busy_early); end
        n_checks++; if (got_b.size() != 3) begin n_fail++; $display("FAIL g3_count got=%0d exp=3", got_b.size()); end
        for (int i = 0; i < 3 && i < got_b.size(); i++) begin
            n_checks++; if (got_b[i] !== 8'hFF) begin n_fail++; $display("FAIL g3_byte%0d got=%h exp=ff", i, got_b[i]); end
        end
        if (got_c.size() > 0) begin
            n_checks++; if (got_c[0] - start_cyc != 4) begin n_fail++; $display("FAIL g3_latency got=%0d exp=4", got_c[0] - start_cyc); end
        end
    endtask

    task automatic test_stall;
        int k;
        for (int i = 40; i < 43; i++) ram[i] = 24'($urandom);
        build_expected(1, 40, 3);
        got_b.delete(); got_a.delete(); got_c.delete(); done_cnt = 0; viol = 0;
        @(negedge clk); #1;
        mode = 2'd1; base_addr = 10'd40; len = 10'd3; start = 1'b1;
        @(negedge clk); #1;
        start = 1'b0;
        k = 0;
        while (got_b.size() < 1 && k < 50) begin @(negedge clk); #1; k++; end
        n_checks++; if (got_b.size() != 1) begin n_fail++; $display("FAIL stall_first_byte got=%0d exp=1", got_b.size()); end
        tx_full = 1'b1;
        repeat (10) @(negedge clk);
        #1;
        n_checks++; if (got_b.size() != 1) begin n_fail++; $display("FAIL stall_no_strobe got=%0d exp=1", got_b.size()); end
        n_checks++; if (w_data !== exp_b[0]) begin n_fail++; $display("FAIL stall_w_data_hold got=%h exp=%h", w_data, exp_b[0]); end
        tx_full = 1'b0;
        k = 0;
        while (done_cnt == 0 && k < 100) begin @(negedge clk); #1; k++; end
        n_checks++; if (done_cnt != 1) begin n_fail++; $display("FAIL stall_done got=%0d exp=1", done_cnt); end
        n_checks++; if (got_b != exp_b) begin n_fail++; $display("FAIL stall_sequence got=%p exp=%p", got_b, exp_b); end
        n_checks++; if (viol != 0) begin n_fail++; $display("FAIL stall_strobe_while_full got=%0d exp=0", viol); end
    endtask

    task automatic test_wrap;
        ram[1023] = 24'($urandom); ram[0] = 24'($urandom);
        build_expected(1, 1023, 2);
        do_run(1, 1023, 2, 0, 1'b0, 1'b0);
        n_checks++; if (got_a != exp_a) begin n_fail++; $display("FAIL wrap_addr got=%p exp=%p", got_a, exp_a); end
        n_checks++; if (got_b != exp_b) begin n_fail++; $display("FAIL wrap_bytes got=%p exp=%p", got_b, exp_b); end
    endtask

    task automatic test_len0_ignore_start;
        int base, bad;
        for (int i = 0; i < NPIX; i++) ram[i] = 24'($urandom);
        base = int'($urandom_range(1023));
        build_expected(0, base, NPIX);
        do_run(0, base, 0, 0, 1'b1, 1'b0);
        n_checks++; if (got_b.size() != NPIX) begin n_fail++; $display("FAIL len0_count got=%0d exp=%0d", got_b.size(), NPIX); end
        bad = 0;
        for (int i = 0; i < NPIX && i < got_b.size(); i++)
            if (got_b[i] !== exp_b[i] || got_a[i] != exp_a[i]) bad++;
        n_checks++; if (bad != 0) begin n_fail++; $display("FAIL len0_content got=%0d_bad exp=0_bad", bad); end
        n_checks++; if (done_cnt != 1 || done_cyc - start_cyc != 4 + 1023 * 4 + 1) begin
            n_fail++; $display("FAIL len0_done got=%0d@%0d exp=1@%0d", done_cnt, done_cyc - start_cyc, 4 + 1023 * 4 + 1); end
    endtask

    task automatic test_reset_abort;
        int k;
        for (int i = 10; i < 13; i++) ram[i] = 24'($urandom);
        got_b.delete(); got_a.delete(); got_c.delete(); done_cnt = 0;
        @(negedge clk); #1;
        mode = 2'd1; base_addr = 10'd10; len = 10'd3; start = 1'b1;
        @(negedge clk); #1;
        start = 1'b0;
        k = 0;
        while (got_b.size() < 1 && k < 50) begin @(negedge clk); #1; k++; end
        reset = 1'b1;
        @(negedge clk); #1;
        n_checks++; if (wr_uart !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
            n_fail++; $display("FAIL abort_outputs got=%b%b%b exp=000", wr_uart, busy, done); end
        reset = 1'b0;
        repeat (10) @(negedge clk);
        #1;
        n_checks++; if (got_b.size() != 1 || done_cnt != 0) begin
            n_fail++; $display("FAIL abort_quiet got=%0d_bytes_%0d_done exp=1_bytes_0_done", got_b.size(), done_cnt); end
        build_expected(1, 10, 3);
        do_run(1, 10, 3, 0, 1'b0, 1'b0);
        n_checks++; if (got_b != exp_b || got_a != exp_a) begin n_fail++; $display("FAIL abort_restart got=%p exp=%p", got_b, exp_b); end
        if (got_c.size() > 0) begin
            n_checks++; if (got_c[0] - start_cyc != 4) begin n_fail++; $display("FAIL abort_restart_latency got=%0d exp=4", got_c[0] - start_cyc); end
        end
    endtask

    task automatic test_done_start;
        int nb;
        ram[100] = 24'($urandom);
        build_expected(0, 100, 1);
        do_run(0, 100, 1, 0, 1'b0, 1'b1);
        nb = got_b.size();
        n_checks++; if (nb != 1 || busy !== 1'b0) begin
            n_fail++; $display("FAIL done_start_ignored got=%0d_bytes_busy%b exp=1_bytes_busy0", nb, busy); end
    endtask

    task automatic test_random;
        int m, base, l, me;
        for (int it = 0; it < 6; it++) begin
            m = int'($urandom_range(3));
            base = int'($urandom_range(1023));
            l = int'($urandom_range(12, 1));
            for (int p = 0; p < l; p++) ram[(base + p) % NPIX] = 24'($urandom);
            me = (m == 3) ? 0 : m;
            build_expected(me, base, l);
            do_run(m, base, l, 30, 1'b0, 1'b0);
            n_checks++; if (got_b != exp_b || got_a != exp_a) begin
                n_fail++; $display("FAIL rand%0d_stream m=%0d got=%p exp=%p", it, m, got_b, exp_b); end
            n_checks++; if (done_cnt != 1 || viol != 0) begin
                n_fail++; $display("FAIL rand%0d_done_flow got=%0d/%0d exp=1/0", it, done_cnt, viol); end
        end
    endtask

    initial begin
        for (int i = 0; i < NPIX; i++) ram[i] = 24'd0;
        test_reset();
        test_gray_basic();
        test_rgb();
        test_gray3_latency();
        test_stall();
        test_wrap();
        test_len0_ignore_start();
        test_reset_abort();
        test_done_start();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
